// File: rtl/wavetable_pkg.sv
// Shared types and widths for the wavetable responder.
// Widths here are the build-wide defaults used by every file.
package wavetable_pkg;

  localparam int A_WIDTH = 12;
  localparam int D_WIDTH = 16;
  localparam int T_WIDTH = 3;
  localparam int M_WIDTH = 16;
  localparam int RAM_AW  = T_WIDTH + A_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    R0,
    R1,
    R2,
    R3,
    CAP
  } state_t;

  typedef logic [1:0][D_WIDTH-1:0] sample_pair_t;

  typedef struct packed {
    logic [T_WIDTH-1:0] t;
    logic [T_WIDTH-1:0] t2;
    logic [M_WIDTH-1:0] frac;
  } morph_split_t;

  // Last table has no neighbour, so it interpolates against itself.
  function automatic morph_split_t split_morph(
    input logic [M_WIDTH-1:0] m
  );
    morph_split_t s;
    s.t    = m[M_WIDTH-1 -: T_WIDTH];
    s.t2   = (&s.t) ? s.t : s.t + 1'b1;
    s.frac = m << T_WIDTH;
    return s;
  endfunction

endpackage

// File: rtl/wavetable_if.sv
// Read/write bus between voices, host loader and the responder.
// slave = responder side, master = voice/host side.
interface wavetable_if;
  import wavetable_pkg::*;

  logic                readEn;
  logic [A_WIDTH-1:0]  addrIn;
  logic [M_WIDTH-1:0]  morph;
  sample_pair_t        samplesInterp;
  sample_pair_t        samplesAnti;
  logic [M_WIDTH-1:0]  tableInterp;
  logic                valid;
  logic                busy;
  logic                overrun;
  logic                wrEn;
  logic [RAM_AW-1:0]   wrAddr;
  logic [D_WIDTH-1:0]  wrData;
  logic                wrReady;

  modport slave (
    input  readEn, addrIn, morph,
    input  wrEn, wrAddr, wrData,
    output samplesInterp, samplesAnti,
    output tableInterp, valid, busy,
    output overrun, wrReady
  );

  modport master (
    output readEn, addrIn, morph,
    output wrEn, wrAddr, wrData,
    input  samplesInterp, samplesAnti,
    input  tableInterp, valid, busy,
    input  overrun, wrReady
  );

endinterface

// File: rtl/wavetable_ram.sv
// Single-port wavetable store, synchronous read, 1-cycle latency.
// No reset: contents survive Reset_n.
module wavetable_ram
  import wavetable_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [RAM_AW-1:0]  i_addr,
  input  logic [D_WIDTH-1:0] i_wdata,
  output logic [D_WIDTH-1:0] o_rdata
);

  logic [D_WIDTH-1:0] r_mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/wavetable_responder.sv
// Four-read wavetable responder (t/t+1, addr/addr+1).
// Define WT_PENDING_EN for a one-deep pending request slot.
module wavetable_responder
  import wavetable_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  wavetable_if.slave bus
);

  state_t              r_state, w_next;
  logic [A_WIDTH-1:0]  r_addr, w_addr_p1, w_ld_addr;
  logic [T_WIDTH-1:0]  r_t, r_t2;
  logic [M_WIDTH-1:0]  r_frac, w_ld_morph;
  logic [2:0][D_WIDTH-1:0] r_stage;
  sample_pair_t        r_interp, r_anti;
  logic [M_WIDTH-1:0]  r_tinterp;
  logic                r_valid, r_overrun;
  logic                w_busy, w_load, w_ovr;
  logic                w_wr_ready, w_ram_we;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [D_WIDTH-1:0]  w_rdata;
  morph_split_t        w_split;

  assign w_busy     = (r_state != IDLE);
  assign w_wr_ready = (r_state == IDLE) && !bus.readEn;
  assign w_ram_we   = bus.wrEn && w_wr_ready;
  assign w_addr_p1  = r_addr + 1'b1;

`ifdef WT_PENDING_EN
  logic               r_pend;
  logic [A_WIDTH-1:0] r_pend_addr;
  logic [M_WIDTH-1:0] r_pend_morph;
  logic               w_open;

  // CAP can chain straight into R0; a live request beats the slot.
  assign w_open     = (r_state == IDLE) || (r_state == CAP);
  assign w_load     = (w_open && bus.readEn) ||
                      ((r_state == CAP) && r_pend);
  assign w_ovr      = bus.readEn && w_busy && r_pend;
  assign w_ld_addr  = bus.readEn ? bus.addrIn : r_pend_addr;
  assign w_ld_morph = bus.readEn ? bus.morph  : r_pend_morph;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_morph <= '0;
    end else if (w_busy && r_state != CAP && bus.readEn) begin
      r_pend       <= 1'b1;
      r_pend_addr  <= bus.addrIn;
      r_pend_morph <= bus.morph;
    end else if (r_state == CAP) begin
      r_pend       <= 1'b0;
    end
  end
`else
  assign w_load     = (r_state == IDLE) && bus.readEn;
  assign w_ovr      = bus.readEn && w_busy;
  assign w_ld_addr  = bus.addrIn;
  assign w_ld_morph = bus.morph;
`endif

  assign w_split = split_morph(w_ld_morph);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_load) w_next = R0;
      R0:      w_next = R1;
      R1:      w_next = R2;
      R2:      w_next = R3;
      R3:      w_next = CAP;
      CAP:     w_next = w_load ? R0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ram_addr = bus.wrAddr;
    unique case (r_state)
      R0:      w_ram_addr = {r_t, r_addr};
      R1:      w_ram_addr = {r_t, w_addr_p1};
      R2:      w_ram_addr = {r_t2, r_addr};
      R3:      w_ram_addr = {r_t2, w_addr_p1};
      default: w_ram_addr = bus.wrAddr;
    endcase
  end

  wavetable_ram u_ram (
    .clk     (Clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (bus.wrData),
    .o_rdata (w_rdata)
  );

  // Each state captures the read issued one state earlier.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr    <= '0;
      r_t       <= '0;
      r_t2      <= '0;
      r_frac    <= '0;
      r_stage   <= '0;
      r_interp  <= '0;
      r_anti    <= '0;
      r_tinterp <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= (r_state == CAP);
      if (w_ovr)
        r_overrun <= 1'b1;
      if (w_load) begin
        r_addr <= w_ld_addr;
        r_t    <= w_split.t;
        r_t2   <= w_split.t2;
        r_frac <= w_split.frac;
      end
      unique case (r_state)
        R1: r_stage[0] <= w_rdata;
        R2: r_stage[1] <= w_rdata;
        R3: r_stage[2] <= w_rdata;
        CAP: begin
          r_interp  <= {r_stage[1], r_stage[0]};
          r_anti    <= {w_rdata, r_stage[2]};
          r_tinterp <= r_frac;
        end
        default: ;
      endcase
    end
  end

  assign bus.samplesInterp = r_interp;
  assign bus.samplesAnti   = r_anti;
  assign bus.tableInterp   = r_tinterp;
  assign bus.valid         = r_valid;
  assign bus.busy          = w_busy;
  assign bus.overrun       = r_overrun;
  assign bus.wrReady       = w_wr_ready;

endmodule

// File: tb/tb_wavetable_responder.sv
// Bench for wavetable_responder: vector table plus scoreboard.
// Build with or without WT_PENDING_EN to match the RTL.
module tb_wavetable_responder;
  import wavetable_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wavetable_if bus();

  wavetable_responder dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [A_WIDTH-1:0] addr;
    logic [15:0]        morph;
    logic [15:0]        i0, i1, a0, a1;
    logic [15:0]        ti;
  } vec_t;

  typedef struct {
    sample_pair_t interp;
    sample_pair_t anti;
    logic [15:0]  ti;
  } exp_t;

  typedef struct {
    logic [T_WIDTH-1:0] t;
    logic [A_WIDTH-1:0] a;
    logic [15:0]        d;
  } wr_t;

  exp_t sb[$];
  int   vt[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[4];
  wr_t  wrs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.interp = {v.i1, v.i0};
    e.anti   = {v.a1, v.a0};
    e.ti     = v.ti;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.valid) begin
      vt.push_back(cyc);
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("samplesInterp", bus.samplesInterp, e.interp);
        check("samplesAnti", bus.samplesAnti, e.anti);
        check("tableInterp", bus.tableInterp, e.ti);
      end
    end
  end

  task automatic wr(input logic [T_WIDTH-1:0] t,
                    input logic [A_WIDTH-1:0] a,
                    input logic [15:0] d);
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrAddr = {t, a};
    bus.wrData = d;
    #1 check("wrReady_idle", bus.wrReady, 1);
    @(negedge clk);
    bus.wrEn = 1'b0;
  endtask

  task automatic req(input logic [A_WIDTH-1:0] a,
                     input logic [15:0] m,
                     output int k);
    @(negedge clk);
    bus.readEn = 1'b1;
    bus.addrIn = a;
    bus.morph  = m;
    @(posedge clk);
    #1;
    k = cyc;
    bus.readEn = 1'b0;
  endtask

  task automatic wait_valids(input int n, input int budget);
    int c = 0;
    while (vt.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("valid_timeout", vt.size() >= n, 1);
  endtask

  task automatic single(input vec_t v);
    int k;
    vt.delete();
    sb.push_back(mk_exp(v));
    req(v.addr, v.morph, k);
    @(negedge clk);
    #1 check("busy_after_req", bus.busy, 1);
    wait_valids(1, 20);
    if (vt.size() > 0)
      check("latency", vt[0] - k, 5);
    check("busy_after_valid", bus.busy, 0);
  endtask

  initial begin
    int k, kb;
    vecs[0] = '{12'h005, 16'h4800, 16'h1111, 16'h2222,
                16'h3333, 16'h4444, 16'h4000};
    vecs[1] = '{12'hFFF, 16'h0000, 16'hAAAA, 16'h5555,
                16'hBBBB, 16'hCCCC, 16'h0000};
    vecs[2] = '{12'h00A, 16'hE000, 16'h7777, 16'h8888,
                16'h7777, 16'h8888, 16'h0000};
    vecs[3] = '{12'h006, 16'h5FFF, 16'h2222, 16'h9999,
                16'h4444, 16'hDDDD, 16'hFFF8};
    wrs[0]  = '{3'd2, 12'h005, 16'h1111};
    wrs[1]  = '{3'd2, 12'h006, 16'h2222};
    wrs[2]  = '{3'd2, 12'h007, 16'h9999};
    wrs[3]  = '{3'd3, 12'h005, 16'h3333};
    wrs[4]  = '{3'd3, 12'h006, 16'h4444};
    wrs[5]  = '{3'd3, 12'h007, 16'hDDDD};
    wrs[6]  = '{3'd0, 12'hFFF, 16'hAAAA};
    wrs[7]  = '{3'd0, 12'h000, 16'h5555};
    wrs[8]  = '{3'd1, 12'hFFF, 16'hBBBB};
    wrs[9]  = '{3'd1, 12'h000, 16'hCCCC};
    wrs[10] = '{3'd7, 12'h00A, 16'h7777};
    wrs[11] = '{3'd7, 12'h00B, 16'h8888};

    bus.readEn = 1'b0;
    bus.addrIn = '0;
    bus.morph  = '0;
    bus.wrEn   = 1'b0;
    bus.wrAddr = '0;
    bus.wrData = '0;

    repeat (3) @(negedge clk);
    check("rst_interp", bus.samplesInterp, 0);
    check("rst_anti", bus.samplesAnti, 0);
    check("rst_tinterp", bus.tableInterp, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_wrReady", bus.wrReady, 1);
    rst_n = 1'b1;

    foreach (wrs[i]) wr(wrs[i].t, wrs[i].a, wrs[i].d);
    for (int i = 0; i < 4; i++) single(vecs[i]);

    // write at edge k, read sampled at edge k+1
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrAddr = {3'd7, 12'h00C};
    bus.wrData = 16'h0F0F;
    @(negedge clk);
    bus.wrEn   = 1'b0;
    vt.delete();
    sb.push_back('{{16'h0F0F, 16'h8888},
                   {16'h0F0F, 16'h8888}, 16'h0000});
    bus.readEn = 1'b1;
    bus.addrIn = 12'h00B;
    bus.morph  = 16'hE000;
    @(posedge clk);
    #1 bus.readEn = 1'b0;
    wait_valids(1, 20);

`ifdef WT_PENDING_EN
    vt.delete();
    sb.push_back(mk_exp(vecs[0]));
    sb.push_back(mk_exp(vecs[3]));
    req(vecs[0].addr, vecs[0].morph, k);
    @(negedge clk);
    req(vecs[3].addr, vecs[3].morph, kb);
    check("b2b_spacing", kb - k, 2);
    wait_valids(2, 30);
    if (vt.size() > 1) begin
      check("pend_first", vt[0] - k, 5);
      check("pend_second", vt[1] - k, 10);
    end
    check("pend_no_overrun", bus.overrun, 0);

    vt.delete();
    sb.push_back(mk_exp(vecs[0]));
    sb.push_back(mk_exp(vecs[2]));
    req(vecs[0].addr, vecs[0].morph, k);
    @(negedge clk);
    req(vecs[3].addr, vecs[3].morph, kb);
    req(vecs[2].addr, vecs[2].morph, kb);
    wait_valids(2, 30);
    if (vt.size() > 1) begin
      check("newest_first", vt[0] - k, 5);
      check("newest_second", vt[1] - k, 10);
    end
    repeat (10) @(negedge clk);
    check("newest_count", vt.size(), 2);
    check("pend_overrun", bus.overrun, 1);
`else
    vt.delete();
    sb.push_back(mk_exp(vecs[0]));
    req(vecs[0].addr, vecs[0].morph, k);
    @(negedge clk);
    req(vecs[3].addr, vecs[3].morph, kb);
    check("b2b_spacing", kb - k, 2);
    wait_valids(1, 20);
    repeat (10) @(negedge clk);
    check("drop_count", vt.size(), 1);
    if (vt.size() > 0)
      check("drop_latency", vt[0] - k, 5);
    check("drop_overrun", bus.overrun, 1);
`endif

    // write attempted while busy must be ignored
    vt.delete();
    sb.push_back(mk_exp(vecs[0]));
    req(vecs[0].addr, vecs[0].morph, k);
    @(negedge clk);
    bus.wrEn   = 1'b1;
    bus.wrAddr = {3'd2, 12'h005};
    bus.wrData = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1 check("wrReady_busy", bus.wrReady, 0);
      @(negedge clk);
    end
    bus.wrEn = 1'b0;
    wait_valids(1, 20);
    single(vecs[0]);

    // read beats write in the same IDLE cycle
    vt.delete();
    sb.push_back(mk_exp(vecs[0]));
    @(negedge clk);
    bus.readEn = 1'b1;
    bus.addrIn = vecs[0].addr;
    bus.morph  = vecs[0].morph;
    bus.wrEn   = 1'b1;
    bus.wrAddr = {3'd2, 12'h005};
    bus.wrData = 16'hBEEF;
    #1 check("wrReady_readEn", bus.wrReady, 0);
    @(posedge clk);
    #1;
    bus.readEn = 1'b0;
    bus.wrEn   = 1'b0;
    wait_valids(1, 20);
    single(vecs[0]);

    // reset during R2
    vt.delete();
    req(vecs[3].addr, vecs[3].morph, k);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_interp", bus.samplesInterp, 0);
    check("mid_rst_anti", bus.samplesAnti, 0);
    check("mid_rst_tinterp", bus.tableInterp, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_valid_after_rst", vt.size(), 0);
    single(vecs[0]);
    single(vecs[1]);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
